result_writer: RTL

Drain side of the accumulator: captures each finished 256-bit accumulated result block (16 lanes × 16 bits) when the accumulator signals done. Buffers up to two blocks and serialises each block into 16 single-lane memory writes over a valid/ready write port with an auto-incrementing address. It sits between the accumulator and the result memory / host readback path.

---
 rtl/mb_pkg.sv | 13 +
 rtl/result_fifo.sv | 63 ++++++
 rtl/result_writer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// Shared constants for the result drain path: block geometry and writer FSM encodings.
// Lane i of a block occupies bits [BlockW-1-DATA_W*i -: DATA_W], so lane 0 is the MSB slice.
package mb_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BlockW = LANES * DATA_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;

endpackage

// File: rtl/result_fifo.sv
// Two-entry block FIFO between the accumulator capture and the lane serialiser.
// A push while full is accepted only when a pop happens in the same cycle.
module result_fifo #(
  parameter int unsigned Width = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == 2'd2);
    empty_o = (count_q == 2'd0);
    head_o  = mem_q[rd_ptr_q];
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Captures finished accumulator blocks on done rising edges and serialises each into
// LANES single-lane writes at an auto-incrementing address.
module result_writer
  import mb_pkg::*;
#(
  parameter int unsigned LANES  = mb_pkg::LANES,
  parameter int unsigned DATA_W = mb_pkg::DATA_W,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    acc_done,
  input  logic [LANES*DATA_W-1:0] acc_data,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    overflow,
  output logic [7:0]              blocks_written
);

  localparam int unsigned BlkW     = LANES * DATA_W;
  localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                done_q;
  logic [1:0]          state_q, state_d;
  logic [BlkW-1:0]     shift_q, shift_d;
  logic [LaneIdxW-1:0] lane_idx_q, lane_idx_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          blocks_q, blocks_d;
  logic                overflow_q, overflow_d;

  logic            capture, push, pop;
  logic            fifo_full, fifo_empty;
  logic [BlkW-1:0] fifo_head;

  result_fifo #(
    .Width (BlkW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (acc_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    capture    = acc_done & ~done_q;
    pop        = (state_q == StLoad);
    push       = capture && (!fifo_full || pop);
    overflow_d = overflow_q | (capture & fifo_full & ~pop);

    state_d    = state_q;
    shift_d    = shift_q;
    lane_idx_d = lane_idx_q;
    ptr_d      = ptr_q;
    blocks_d   = blocks_q;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StLoad;
        end else if (start) begin
          ptr_d    = start_addr;
          blocks_d = 8'd0;
        end
      end
      StLoad: begin
        shift_d    = fifo_head;
        lane_idx_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (wr_ready) begin
          shift_d    = shift_q << DATA_W;
          ptr_d      = ptr_q + 1'b1;
          lane_idx_d = lane_idx_q + 1'b1;
          if (lane_idx_q == LaneIdxW'(LANES - 1)) begin
            blocks_d = blocks_q + 8'd1;
            // No pop in SEND, so only this cycle's push can refill an empty FIFO.
            state_d  = (!fifo_empty || push) ? StLoad : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      state_q    <= StIdle;
      shift_q    <= '0;
      lane_idx_q <= '0;
      ptr_q      <= '0;
      blocks_q   <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= acc_done;
      state_q    <= state_d;
      shift_q    <= shift_d;
      lane_idx_q <= lane_idx_d;
      ptr_q      <= ptr_d;
      blocks_q   <= blocks_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    wr_valid       = (state_q == StSend);
    wr_addr        = ptr_q;
    wr_data        = shift_q[BlkW-1 -: DATA_W];
    busy           = (state_q != StIdle) || !fifo_empty;
    overflow       = overflow_q;
    blocks_written = blocks_q;
  end

endmodule
